// File: rtl/aes_wddl_pkg.sv
// ---------------------------------------------------------------------------
// aes_wddl_pkg
// Shared types for the dual-rail (WDDL) AddRoundKey stage:
//   state_e   - sequencing FSM states (IDLE, EVAL, PRE)
//   MODE_*    - operation select encodings
//   dr_bit_t  - one dual-rail bit: (1,0)=1, (0,1)=0, (0,0)=precharge, (1,1)=illegal
//   dr_xor()  - rail-level XOR of two dual-rail bits (no decode, no inversion)
// ---------------------------------------------------------------------------
package aes_wddl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        PRE  = 2'd2
    } state_e;

    localparam logic [1:0] MODE_PASS = 2'd0;
    localparam logic [1:0] MODE_LOAD = 2'd1;
    localparam logic [1:0] MODE_ARK  = 2'd2;

    typedef struct packed {
        logic p;
        logic n;
    } dr_bit_t;

    // Both rails are built from AND/OR only, so a precharged operand
    // (0,0) propagates as a precharged result.
    function automatic dr_bit_t dr_xor(input dr_bit_t a, input dr_bit_t b);
        dr_bit_t y;
        y.p = (a.p & b.n) | (a.n & b.p);
        y.n = (a.p & b.p) | (a.n & b.n);
        return y;
    endfunction

endpackage

// File: rtl/wddl_xor2.sv
// ---------------------------------------------------------------------------
// wddl_xor2
// Purely combinational W-bit dual-rail XOR, y = a ^ b, evaluated per bit
// pair with rail-level AND/OR gates only.
// Ports:
//   i_a_p / i_a_n : operand a, true/false rails
//   i_b_p / i_b_n : operand b, true/false rails
//   o_y_p / o_y_n : result, true/false rails
// ---------------------------------------------------------------------------
module wddl_xor2
    import aes_wddl_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a_p,
    input  logic [W-1:0] i_a_n,
    input  logic [W-1:0] i_b_p,
    input  logic [W-1:0] i_b_n,
    output logic [W-1:0] o_y_p,
    output logic [W-1:0] o_y_n
);

    for (genvar g = 0; g < W; g++) begin : g_bit
        dr_bit_t w_a;
        dr_bit_t w_b;
        dr_bit_t w_y;
        assign w_a      = {i_a_p[g], i_a_n[g]};
        assign w_b      = {i_b_p[g], i_b_n[g]};
        assign w_y      = dr_xor(w_a, w_b);
        assign o_y_p[g] = w_y.p;
        assign o_y_n[g] = w_y.n;
    end

endmodule

// File: rtl/aes_ark_wddl_seq.sv
// ---------------------------------------------------------------------------
// aes_ark_wddl_seq
// Handshaked dual-rail AddRoundKey stage with explicit WDDL precharge
// sequencing. One transaction is accepted in IDLE, held in EVAL until the
// downstream takes it, then the outputs sit at all-zero precharge for
// PRE_CYC cycles before the next accept.
// Parameters:
//   NBYTES  - state bytes per transaction (W = 8*NBYTES)
//   PRE_CYC - precharge cycles after each output handshake (1..15)
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid / in_ready - input handshake
//   mode                - 0 PASS, 1 LOAD, 2 ARK, 3 reserved (acts as PASS)
//   text_in(_n)         - plaintext rails
//   w_i(_n)             - round key rails
//   sa_i(_n)            - current state rails
//   out_valid/out_ready - output handshake
//   sa_o(_n)            - registered result rails
//   rail_err            - sticky encoding error flag
// Build option:
//   WDDL_RAIL_CHECK_EN  - when defined, rail_err flags malformed operand
//                         pairs and mode 3 on accept; otherwise tied to 0.
// ---------------------------------------------------------------------------
module aes_ark_wddl_seq
    import aes_wddl_pkg::*;
#(
    parameter  int NBYTES  = 16,
    parameter  int PRE_CYC = 1,
    localparam int W       = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   mode,
    input  logic [W-1:0] text_in,
    input  logic [W-1:0] text_in_n,
    input  logic [W-1:0] w_i,
    input  logic [W-1:0] w_i_n,
    input  logic [W-1:0] sa_i,
    input  logic [W-1:0] sa_i_n,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sa_o,
    output logic [W-1:0] sa_o_n,
    output logic         rail_err
);

    if (PRE_CYC < 1 || PRE_CYC > 15) begin : g_bad_pre_cyc
        $error("aes_ark_wddl_seq: PRE_CYC must be in 1..15");
    end

    localparam logic [3:0] PRE_LOAD = 4'(PRE_CYC - 1);

    state_e       r_state;
    state_e       w_state_nxt;
    logic [3:0]   r_cnt;
    logic [W-1:0] r_sa_o;
    logic [W-1:0] r_sa_o_n;
    logic         w_accept;
    logic         w_release;

    logic [W-1:0] w_load_p;
    logic [W-1:0] w_load_n;
    logic [W-1:0] w_ark_p;
    logic [W-1:0] w_ark_n;
    logic [W-1:0] w_res_p;
    logic [W-1:0] w_res_n;

    wddl_xor2 #(.W(W)) u_xor_load (
        .i_a_p (text_in),
        .i_a_n (text_in_n),
        .i_b_p (w_i),
        .i_b_n (w_i_n),
        .o_y_p (w_load_p),
        .o_y_n (w_load_n)
    );

    wddl_xor2 #(.W(W)) u_xor_ark (
        .i_a_p (sa_i),
        .i_a_n (sa_i_n),
        .i_b_p (w_i),
        .i_b_n (w_i_n),
        .o_y_p (w_ark_p),
        .o_y_n (w_ark_n)
    );

    // Mode mux: rails are selected as a pair, never recombined.
    // NOTE: every signal driven in an always_comb gets a default first, so no
    // path through the case statement can leave it unassigned and infer a latch.
    always_comb begin
        w_res_p = sa_i;
        w_res_n = sa_i_n;
        case (mode)
            MODE_LOAD: begin
                w_res_p = w_load_p;
                w_res_n = w_load_n;
            end
            MODE_ARK: begin
                w_res_p = w_ark_p;
                w_res_n = w_ark_n;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement or process order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_accept    = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = EVAL;
                end
            end
            EVAL: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_release   = 1'b1;
                    w_state_nxt = PRE;
                end
            end
            PRE: begin
                if (r_cnt == '0) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: the output rails are reset because (0,0) is the precharge value
    // SubBytes must see; leaving them unknown would present illegal pairs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sa_o   <= '0;
            r_sa_o_n <= '0;
        end else if (w_accept) begin
            r_sa_o   <= w_res_p;
            r_sa_o_n <= w_res_n;
        end else if (w_release) begin
            r_sa_o   <= '0;
            r_sa_o_n <= '0;
        end
    end

    // Precharge counter: loaded on the output handshake, exits PRE at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                r_cnt <= '0;
        else if (w_release)                     r_cnt <= PRE_LOAD;
        else if (r_state == PRE && r_cnt != '0) r_cnt <= r_cnt - 4'd1;
    end

    assign sa_o   = r_sa_o;
    assign sa_o_n = r_sa_o_n;

`ifdef WDDL_RAIL_CHECK_EN
    // A pair is malformed when both rails agree: (1,1) or (0,0).
    logic w_text_bad;
    logic w_key_bad;
    logic w_sa_bad;
    logic w_chk_err;
    logic r_rail_err;

    assign w_text_bad = |(~(text_in ^ text_in_n));
    assign w_key_bad  = |(~(w_i ^ w_i_n));
    assign w_sa_bad   = |(~(sa_i ^ sa_i_n));

    // Only operands the selected mode actually consumes are checked.
    always_comb begin
        w_chk_err = 1'b0;
        case (mode)
            MODE_PASS: w_chk_err = w_sa_bad;
            MODE_LOAD: w_chk_err = w_text_bad | w_key_bad;
            MODE_ARK:  w_chk_err = w_sa_bad | w_key_bad;
            default:   w_chk_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        r_rail_err <= 1'b0;
        else if (w_accept && w_chk_err) r_rail_err <= 1'b1;
    end

    assign rail_err = r_rail_err;
`else
    assign rail_err = 1'b0;
`endif

endmodule

// File: tb/tb_aes_ark_wddl_seq.sv
// ---------------------------------------------------------------------------
// tb_aes_ark_wddl_seq
// Directed bench for aes_ark_wddl_seq (NBYTES=16, PRE_CYC=3) with
// hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_aes_ark_wddl_seq;

    localparam int TB_PRE = 3;
    localparam int W      = 128;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   mode;
    logic [W-1:0] text_in, text_in_n;
    logic [W-1:0] w_i, w_i_n;
    logic [W-1:0] sa_i, sa_i_n;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sa_o, sa_o_n;
    logic         rail_err;

    int n_checks = 0;
    int n_bad    = 0;
    int cyc      = 0;
    logic exp_err = 1'b0;

    localparam logic [W-1:0] TEXT  = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [W-1:0] KEY   = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [W-1:0] T_X_K = 128'h0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFFF;
    localparam logic [W-1:0] ALLF  = {16{8'hFF}};
    localparam logic [W-1:0] A5    = {16{8'hA5}};
    localparam logic [W-1:0] A5_K  = 128'hAAABA8A9AEAFACADA2A3A0A1A6A7A4A5;
    localparam logic [W-1:0] C3C   = {16{8'h3C}};

    aes_ark_wddl_seq #(.NBYTES(16), .PRE_CYC(TB_PRE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .text_in   (text_in),
        .text_in_n (text_in_n),
        .w_i       (w_i),
        .w_i_n     (w_i_n),
        .sa_i      (sa_i),
        .sa_i_n    (sa_i_n),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sa_o      (sa_o),
        .sa_o_n    (sa_o_n),
        .rail_err  (rail_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ops(input logic [1:0] m, input logic [W-1:0] t,
                             input logic [W-1:0] k, input logic [W-1:0] s);
        mode      = m;
        text_in   = t;  text_in_n = ~t;
        w_i       = k;  w_i_n     = ~k;
        sa_i      = s;  sa_i_n    = ~s;
    endtask

    // Counts precharge cycles (not ready, not valid) and requires all-zero rails.
    task automatic count_pre(input string tag);
        int n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            check({tag, ".pre_zero"}, sa_o | sa_o_n, '0);
            check({tag, ".pre_vld"}, W'(out_valid), '0);
            n++;
            step();
        end
        check({tag, ".pre_len"}, W'(n), W'(TB_PRE));
        check({tag, ".idle_zero"}, sa_o | sa_o_n, '0);
    endtask

    task automatic run_txn(input string tag, input logic [W-1:0] ep, input bit chk_data);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        check({tag, ".vld"}, W'(out_valid), W'(1));
        check({tag, ".rdy"}, W'(in_ready), '0);
        if (chk_data) begin
            check({tag, ".sa_o"}, sa_o, ep);
            check({tag, ".sa_o_n"}, sa_o_n, ~ep);
        end
        step();
        count_pre(tag);
        check({tag, ".rail_err"}, W'(rail_err), W'(exp_err));
    endtask

    initial begin
        int acc[$];
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive_ops(2'd0, '0, '0, '0);
        step();
        step();
        check("rst.vld", W'(out_valid), '0);
        check("rst.sa_o", sa_o, '0);
        check("rst.sa_o_n", sa_o_n, '0);
        check("rst.err", W'(rail_err), '0);
        rst = 1'b0;
        step();
        check("rst.rdy", W'(in_ready), W'(1));

        drive_ops(2'd1, TEXT, KEY, A5);
        run_txn("load", T_X_K, 1'b1);
        drive_ops(2'd2, TEXT, ALLF, ALLF);
        run_txn("ark_ff", '0, 1'b1);
        drive_ops(2'd0, TEXT, KEY, A5);
        run_txn("pass", A5, 1'b1);
        drive_ops(2'd2, TEXT, KEY, A5);
        run_txn("ark_a5", A5_K, 1'b1);

        // Back-pressure with a pulsed in_valid that must be ignored.
        drive_ops(2'd1, TEXT, KEY, A5);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp.vld", W'(out_valid), W'(1));
            check("bp.rdy", W'(in_ready), '0);
            check("bp.sa_o", sa_o, T_X_K);
            check("bp.sa_o_n", sa_o_n, ~T_X_K);
            if (i == 2) begin
                drive_ops(2'd0, TEXT, KEY, C3C);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            step();
        end
        // Output handshake and new input in the same cycle: input is dropped.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        check("sim.rdy", W'(in_ready), '0);
        count_pre("sim");
        step();
        check("sim.not_taken", W'(out_valid), '0);

        // Back-to-back accepts spaced 2 + PRE_CYC cycles apart.
        drive_ops(2'd1, TEXT, KEY, A5);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (in_ready === 1'b1) acc.push_back(cyc);
            step();
        end
        in_valid = 1'b0;
        check("b2b.count", W'(acc.size()), W'(4));
        for (int k = 1; k < acc.size(); k++)
            check("b2b.space", W'(acc[k] - acc[k-1]), W'(5));
        for (int i = 0; i < 20 && in_ready !== 1'b1; i++) step();
        check("b2b.drain", W'(in_ready), W'(1));

        // Asynchronous reset in the middle of EVAL.
        drive_ops(2'd1, TEXT, KEY, A5);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid  = 1'b0;
        check("mid.vld", W'(out_valid), W'(1));
        #2 rst = 1'b1;
        #1;
        check("mid.vld0", W'(out_valid), '0);
        check("mid.sa_o", sa_o, '0);
        check("mid.sa_o_n", sa_o_n, '0);
        step();
        rst     = 1'b0;
        exp_err = 1'b0;
        step();
        check("mid.rdy", W'(in_ready), W'(1));
        check("mid.err", W'(rail_err), '0);

        // Rail checker: clean, malformed key bit, clean again, then mode 3.
        drive_ops(2'd2, TEXT, KEY, A5);
        run_txn("chk_clean", A5_K, 1'b1);
        drive_ops(2'd2, TEXT, KEY, A5);
        w_i[0] = 1'b1;
`ifdef WDDL_RAIL_CHECK_EN
        exp_err = 1'b1;
`endif
        run_txn("chk_bad", '0, 1'b0);
        drive_ops(2'd1, TEXT, KEY, A5);
        run_txn("chk_sticky", T_X_K, 1'b1);
        rst = 1'b1;
        step();
        rst     = 1'b0;
        exp_err = 1'b0;
        step();
        check("chk.clr", W'(rail_err), '0);
        drive_ops(2'd3, TEXT, KEY, C3C);
`ifdef WDDL_RAIL_CHECK_EN
        exp_err = 1'b1;
`endif
        run_txn("mode3", C3C, 1'b1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
